// File: rtl/inst_constraint_if.sv
// Decode-side bus of the instruction constraint checker: the decode valid/word
// going in, and the legality verdict, captured word and event counters coming back.
interface inst_constraint_if #(
  parameter int CNT_W = 16
);
  logic             dec_valid_d;
  logic [31:0]      instruction;
  logic             inst_allowed;
  logic [31:0]      inst_q;
  logic             allowed_q;
  logic             violation;
  logic [CNT_W-1:0] valid_cnt;
  logic [CNT_W-1:0] viol_cnt;

  modport master (
    output dec_valid_d,
    output instruction,
    input  inst_allowed,
    input  inst_q,
    input  allowed_q,
    input  violation,
    input  valid_cnt,
    input  viol_cnt
  );

  modport slave (
    input  dec_valid_d,
    input  instruction,
    output inst_allowed,
    output inst_q,
    output allowed_q,
    output violation,
    output valid_cnt,
    output viol_cnt
  );
endinterface

// File: rtl/inst_constraint.sv
// Checks SPARC instructions at decode against a restricted ISA subset and keeps
// a sticky violation flag plus saturating counts of valid and illegal decodes.
module inst_constraint #(
  parameter int REG_LIMIT = 16,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst_n,
  inst_constraint_if.slave   bus
);

  logic [1:0] op;
  logic [4:0] rd;
  logic [2:0] op2;
  logic [5:0] op3;
  logic [4:0] rs1;
  logic       imm;
  logic [4:0] rs2;

  assign op  = bus.instruction[31:30];
  assign rd  = bus.instruction[29:25];
  assign op2 = bus.instruction[24:22];
  assign op3 = bus.instruction[24:19];
  assign rs1 = bus.instruction[18:14];
  assign imm = bus.instruction[13];
  assign rs2 = bus.instruction[4:0];

  logic reg_ok;
  logic branch_ok;
  logic alu_op3_ok;
  logic legal;

  // An immediate-form instruction has no rs2, so only rd and rs1 are bounded.
  assign reg_ok = (int'(rd) < REG_LIMIT) && (int'(rs1) < REG_LIMIT) &&
                  (imm || (int'(rs2) < REG_LIMIT));

  always_comb begin
    branch_ok = 1'b0;
    case (op2)
      3'b001, 3'b010, 3'b011, 3'b100: branch_ok = 1'b1;
      default:                        branch_ok = 1'b0;
    endcase
  end

  // Integer ALU/multiply ops and their cc forms; 011001 is deliberately absent.
  always_comb begin
    alu_op3_ok = 1'b0;
    case (op3) inside
      [6'b000000:6'b001100]:             alu_op3_ok = 1'b1;
      [6'b010000:6'b011000]:             alu_op3_ok = 1'b1;
      6'b011010, 6'b011011, 6'b011100:   alu_op3_ok = 1'b1;
      default:                           alu_op3_ok = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      2'b00:   legal = branch_ok;
      2'b01:   legal = 1'b0;
      2'b10:   legal = alu_op3_ok && reg_ok;
      2'b11:   legal = reg_ok;
      default: legal = 1'b0;
    endcase
  end

  assign bus.inst_allowed = legal;

  logic [31:0]      inst_r;
  logic             allowed_r;
  logic             violation_r;
  logic [CNT_W-1:0] valid_cnt_r;
  logic [CNT_W-1:0] viol_cnt_r;

  // Counters stick at all-ones; violation only leaves 1 through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_r      <= '0;
      allowed_r   <= 1'b0;
      violation_r <= 1'b0;
      valid_cnt_r <= '0;
      viol_cnt_r  <= '0;
    end else if (bus.dec_valid_d) begin
      inst_r    <= bus.instruction;
      allowed_r <= legal;
      if (valid_cnt_r != '1) valid_cnt_r <= valid_cnt_r + CNT_W'(1);
      if (!legal) begin
        violation_r <= 1'b1;
        if (viol_cnt_r != '1) viol_cnt_r <= viol_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.inst_q    = inst_r;
  assign bus.allowed_q = allowed_r;
  assign bus.violation = violation_r;
  assign bus.valid_cnt = valid_cnt_r;
  assign bus.viol_cnt  = viol_cnt_r;

endmodule

// File: tb/tb_inst_constraint.sv
// Directed and random checks of inst_constraint against a field-arithmetic
// legality model and an event-count model, with 4-bit counters to reach saturation.
module tb_inst_constraint;

  localparam int REG_LIMIT = 16;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  inst_constraint_if #(.CNT_W(CNT_W)) bus ();

  inst_constraint #(
    .REG_LIMIT (REG_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  longint m_inst;
  int     m_allowed;
  int     m_viol;
  int     m_vcnt;
  int     m_icnt;

  int alu_ops[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                     16, 17, 18, 19, 20, 21, 22, 23, 24, 26, 27, 28};

  function automatic int model_legal(input logic [31:0] w);
    longint v;
    int op, rd, op2, op3, rs1, i_bit, rs2;
    bit regs_ok, in_alu;
    v     = longint'(w);
    op    = int'(v / (64'd1 << 30));
    rd    = int'((v / (64'd1 << 25)) % 32);
    op2   = int'((v / (64'd1 << 22)) % 8);
    op3   = int'((v / (64'd1 << 19)) % 64);
    rs1   = int'((v / (64'd1 << 14)) % 32);
    i_bit = int'((v / (64'd1 << 13)) % 2);
    rs2   = int'(v % 32);
    regs_ok = (rd < REG_LIMIT) && (rs1 < REG_LIMIT) && (i_bit == 1 || rs2 < REG_LIMIT);
    in_alu = 1'b0;
    foreach (alu_ops[k]) if (alu_ops[k] == op3) in_alu = 1'b1;
    if (op == 0) return (op2 >= 1 && op2 <= 4) ? 1 : 0;
    if (op == 1) return 0;
    if (op == 2) return (in_alu && regs_ok) ? 1 : 0;
    return regs_ok ? 1 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllRegs(input string tag);
    checkOutput({tag, ".inst_q"},    bus.inst_q,            32'(m_inst));
    checkOutput({tag, ".allowed_q"}, 32'(bus.allowed_q),    32'(m_allowed));
    checkOutput({tag, ".violation"}, 32'(bus.violation),    32'(m_viol));
    checkOutput({tag, ".valid_cnt"}, 32'(bus.valid_cnt),    32'(m_vcnt));
    checkOutput({tag, ".viol_cnt"},  32'(bus.viol_cnt),     32'(m_icnt));
  endtask

  // Drives one cycle of inputs, checks the combinational verdict, then the registers.
  task automatic applyStimulus(input string tag, input logic r, input logic v, input logic [31:0] w);
    int leg;
    rst_n           = r;
    bus.dec_valid_d = v;
    bus.instruction = w;
    #1;
    leg = model_legal(w);
    checkOutput({tag, ".inst_allowed"}, 32'(bus.inst_allowed), 32'(leg));
    @(posedge clk);
    if (!r) begin
      m_inst = 0; m_allowed = 0; m_viol = 0; m_vcnt = 0; m_icnt = 0;
    end else if (v) begin
      m_inst    = longint'(w);
      m_allowed = leg;
      m_vcnt    = (m_vcnt < CNT_MAX) ? m_vcnt + 1 : CNT_MAX;
      if (leg == 0) begin
        m_viol = 1;
        m_icnt = (m_icnt < CNT_MAX) ? m_icnt + 1 : CNT_MAX;
      end
    end
    #1;
    checkAllRegs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    m_inst = 0; m_allowed = 0; m_viol = 0; m_vcnt = 0; m_icnt = 0;
    rst_n = 1'b0;
    bus.dec_valid_d = 1'b0;
    bus.instruction = 32'h0;
    @(posedge clk);
    #1;

    // Reset and first legal decode
    applyStimulus("reset", 1'b0, 1'b0, 32'h82008003);
    checkOutput("reset.valid_cnt_zero", 32'(bus.valid_cnt), 32'd0);
    applyStimulus("add_valid", 1'b1, 1'b1, 32'h82008003);
    checkOutput("add.inst_allowed_const", 32'(model_legal(32'h82008003)), 32'd1);
    checkOutput("add.allowed_q_const", 32'(bus.allowed_q), 32'd1);
    checkOutput("add.valid_cnt_const", 32'(bus.valid_cnt), 32'd1);
    checkOutput("add.violation_const", 32'(bus.violation), 32'd0);

    // Combinational legality with decode gated off: registers must hold
    applyStimulus("rd17",  1'b1, 1'b0, 32'hA2008003);
    checkOutput("rd17.allowed_const", 32'(bus.inst_allowed), 32'd0);
    applyStimulus("op3_0d", 1'b1, 1'b0, 32'h82688003);
    checkOutput("op3_0d.allowed_const", 32'(bus.inst_allowed), 32'd0);
    applyStimulus("call",  1'b1, 1'b0, 32'h40000000);
    checkOutput("call.allowed_const", 32'(bus.inst_allowed), 32'd0);
    applyStimulus("nop",   1'b1, 1'b0, 32'h01000000);
    checkOutput("nop.allowed_const", 32'(bus.inst_allowed), 32'd1);
    applyStimulus("load",  1'b1, 1'b0, 32'hC2008003);
    checkOutput("load.allowed_const", 32'(bus.inst_allowed), 32'd1);
    checkOutput("gated.inst_q_const", bus.inst_q, 32'h82008003);
    applyStimulus("op3_19", 1'b1, 1'b0, 32'h80C80003);
    applyStimulus("imm_rs2", 1'b1, 1'b0, 32'h8200601F);
    applyStimulus("rs2_16", 1'b1, 1'b0, 32'h82000010);
    applyStimulus("rs1_16", 1'b1, 1'b0, 32'h82040001);

    // Sticky violation
    applyStimulus("sticky_rst", 1'b0, 1'b0, 32'h0);
    applyStimulus("sticky_call", 1'b1, 1'b1, 32'h40000000);
    applyStimulus("sticky_add",  1'b1, 1'b1, 32'h82008003);
    checkOutput("sticky.violation_const", 32'(bus.violation), 32'd1);
    checkOutput("sticky.viol_cnt_const",  32'(bus.viol_cnt),  32'd1);
    checkOutput("sticky.valid_cnt_const", 32'(bus.valid_cnt), 32'd2);
    checkOutput("sticky.allowed_q_const", 32'(bus.allowed_q), 32'd1);

    // Reset wins over a simultaneous valid decode
    applyStimulus("rst_prio", 1'b0, 1'b1, 32'h40000000);
    checkOutput("rst_prio.inst_q_const", bus.inst_q, 32'h0);

    // Saturation of both counters
    for (int n = 0; n < 20; n++) applyStimulus("sat", 1'b1, 1'b1, 32'h40000000 | 32'(n));
    checkOutput("sat.valid_cnt_const", 32'(bus.valid_cnt), 32'd15);
    checkOutput("sat.viol_cnt_const",  32'(bus.viol_cnt),  32'd15);

    // Random decode traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w[29:25] = 5'($urandom_range(12, 19));
        w[18:14] = 5'($urandom_range(12, 19));
        w[4:0]   = 5'($urandom_range(12, 19));
      end
      if ($urandom_range(0, 2) != 0) w[31:30] = 2'($urandom_range(2, 3));
      applyStimulus("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
